seq_detector_1011: RTL

SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/dff_async_n.sv | 14 +
 rtl/seq_detector_1011.sv | 49 ++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encodings and default counter width for the 1011 detector
package seq_det_pkg;
  localparam int COUNT_W_DEF = 4;
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;
endpackage

// File: rtl/dff_async_n.sv
// dff_async_n: 1-bit falling-edge D flip-flop with asynchronous active-low reset
module dff_async_n (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_bar
);
  // capture d on the falling edge, clear as soon as reset drops
  always_ff @(negedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= d;
  assign q_bar = ~q;
endmodule

// File: rtl/seq_detector_1011.sv
// seq_detector_1011: falling-edge "1011" detector with saturating count; SEQ_OVERLAP_EN selects overlapping detection
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               valid,
  output logic               detect,
  output logic [COUNT_W-1:0] count,
  output logic [2:0]         state
);
  localparam int N = COUNT_W + 4;
`ifdef SEQ_OVERLAP_EN
  localparam state_t S4_ON_ZERO = S2;
`else
  localparam state_t S4_ON_ZERO = S0;
`endif
  logic [N-1:0] d, q, q_bar_unused;
  logic [2:0]   step;
  logic         legal, hit;
  // next state, detect pulse and saturating count; illegal encodings fall back to S0 unconditionally
  always_comb begin
    step = state == S0 ? (din ? S1 : S0) :
           state == S1 ? (din ? S1 : S2) :
           state == S2 ? (din ? S3 : S0) :
           state == S3 ? (din ? S4 : S2) :
           state == S4 ? (din ? S1 : S4_ON_ZERO) : S0;
    legal = state <= S4;
    hit = valid && step == S4;
    d[2:0] = (valid || !legal) ? step : state;
    d[N-2:3] = (hit && !(&count)) ? count + COUNT_W'(1) : count;
    d[N-1] = hit;
  end
  for (genvar i = 0; i < N; i++) begin : g_ff
    dff_async_n u_ff (
      .clk   (clk),
      .reset (reset),
      .d     (d[i]),
      .q     (q[i]),
      .q_bar (q_bar_unused[i])
    );
  end
  assign state  = q[2:0];
  assign count  = q[N-2:3];
  assign detect = q[N-1];
endmodule
